// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Tracks the destination registers of in-flight instructions in a small shadow
// pipeline beside the decode/execute boundary. It does three things:
//   - detects load-use hazards and raises a combinational decode stall,
//   - produces registered EX-stage operand forwarding selects,
//   - keeps a saturating count of stall cycles.
//
// Parameters
//   REG_AW    register-address width
//   ZERO_REG  1: register 0 is hardwired zero and never matches
//   CNT_W     stall counter width
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   id_valid                decode stage holds a real instruction
//   id_rs, id_rt            source register addresses
//   id_rs_use, id_rt_use    the source is actually read
//   id_wr, id_wr_reg        the instruction writes id_wr_reg
//   id_load                 the instruction is a load (result at end of MEM)
//   flush                   squash the decode-stage instruction this cycle
//   cnt_clr                 synchronous clear of stall_cnt
//   stall                   hold IF/ID and inject a bubble into EX
//   fwd_sel_a, fwd_sel_b    00 register file, 01 EX/MEM result, 10 MEM/WB result
//   stall_cnt               saturating stall-cycle count
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_AW   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_load,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              stall,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // What a forwarding source needs to know about a producer.
  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] rd;
  } prod_t;

  // The EX slot also remembers whether its result is late (load).
  typedef struct packed {
    prod_t p;
    logic  load;
  } ex_slot_t;

  // Only EX and MEM are stored. A producer in WB never needs forwarding
  // because the register file writes before it is read, so its slot would
  // carry no information anything here consumes.
  ex_slot_t ex_q;
  prod_t    mem_q;

  logic     advance;
  ex_slot_t ex_d;

  function automatic logic match(prod_t s, logic [REG_AW-1:0] r);
    return s.v & s.wr & (s.rd == r) & ~(ZERO_REG & (r == '0));
  endfunction

  // Youngest producer wins: EX result is newer than MEM result.
  function automatic logic [1:0] sel_for(logic [REG_AW-1:0] r, logic used);
    if (used && match(ex_q.p, r))  return SEL_EX;
    if (used && match(mem_q, r))   return SEL_MEM;
    return SEL_RF;
  endfunction

  // A load in EX cannot forward its result into the very next EX cycle, so a
  // dependent decode instruction waits one cycle. Flush overrides: a squashed
  // instruction is neither held nor counted.
  assign stall = id_valid & ~flush & ex_q.load &
                 ((match(ex_q.p, id_rs) & id_rs_use) |
                  (match(ex_q.p, id_rt) & id_rt_use));

  assign advance = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d = '0;
    if (advance) begin
      ex_d.p.v  = 1'b1;
      ex_d.p.wr = id_wr;
      ex_d.p.rd = id_wr_reg;
      ex_d.load = id_load;
    end
  end

  // NOTE: every register here, slots included, is reset so that no stale
  // producer can trigger a stall or forward right after reset; sequential
  // state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      fwd_sel_a <= SEL_RF;
      fwd_sel_b <= SEL_RF;
      stall_cnt <= '0;
    end else begin
      mem_q <= ex_q.p;
      ex_q  <= ex_d;

      // Selects are computed against the slots the instruction sees while in
      // ID and are then valid for its whole EX cycle; a bubble reads the RF.
      if (advance) begin
        fwd_sel_a <= sel_for(id_rs, id_rs_use);
        fwd_sel_b <= sel_for(id_rt, id_rt_use);
      end else begin
        fwd_sel_a <= SEL_RF;
        fwd_sel_b <= SEL_RF;
      end

      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

endmodule
